// File: rtl/fifo_egress_pkg.sv
// Shared types and default widths for the FIFO-to-AXI4-Stream egress stage.
package fifo_egress_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, BURST = 2'd1, FLUSH = 2'd2} egress_state_t;
  localparam int BLEN_W_DEF = 8;
  localparam int TMO_W_DEF  = 16;
endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry valid/ready buffer. in_space reports the entries still free once this
// cycle's push and drain have been applied, so a registered producer can act on it.
module axis_skid_buf #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         sync_rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic [1:0]   in_space,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready
);
  logic [1:0]   occ_q, occ_d;
  logic [W-1:0] ent0_q, ent0_d, ent1_q, ent1_d;
  logic         drain;

  assign out_valid = (occ_q != 2'd0);
  assign out_data  = ent0_q;
  assign drain     = out_valid & out_ready;
  assign in_space  = 2'd2 - occ_d;

  always_comb begin
    occ_d  = occ_q;
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    case ({in_valid, drain})
      2'b11: begin
        if (occ_q == 2'd2) begin
          ent0_d = ent1_q;
          ent1_d = in_data;
        end else begin
          ent0_d = in_data;
        end
      end
      2'b01: begin
        ent0_d = ent1_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b10: begin
        if (occ_q == 2'd0) ent0_d = in_data;
        else               ent1_d = in_data;
        occ_d = occ_q + 2'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q  <= 2'd0;
      ent0_q <= '0;
      ent1_q <= '0;
    end else if (!sync_rst_n) begin
      occ_q  <= 2'd0;
      ent0_q <= '0;
      ent1_q <= '0;
    end else begin
      occ_q  <= occ_d;
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
    end
  end
endmodule

// File: rtl/fifo_axis_egress.sv
// Drains a shifting FIFO into AXI4-Stream bursts, started by the FIFO watermark
// or by an idle timeout (single-beat flush). Pop is registered; beats go through a skid buffer.
module fifo_axis_egress
  import fifo_egress_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int BLEN_W = BLEN_W_DEF,
  parameter int TMO_W  = TMO_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sync_rst_n,
  input  logic              cfg_enable,
  input  logic [BLEN_W-1:0] cfg_burst_len,
  input  logic [TMO_W-1:0]  cfg_timeout,
  input  logic              fifo_data_valid,
  input  logic [WIDTH-1:0]  fifo_pop_data,
  input  logic              fifo_watermark,
  output logic              fifo_pop,
  output logic              m_tvalid,
  output logic [WIDTH-1:0]  m_tdata,
  output logic              m_tlast,
  input  logic              m_tready,
  output logic              burst_active
);
  egress_state_t     state_q, state_d;
  logic [BLEN_W-1:0] beats_q, beats_d, blen_eff;
  logic [TMO_W-1:0]  idle_q, idle_d;
  logic              pop_q, pop_d, last_q, last_d;
  logic              issue;
  logic [1:0]        space;
  logic [WIDTH:0]    skid_out;

  assign blen_eff     = (cfg_burst_len == '0) ? BLEN_W'(1) : cfg_burst_len;
  assign fifo_pop     = pop_q;
  assign burst_active = (state_q != IDLE);
  assign m_tlast      = skid_out[WIDTH];
  assign m_tdata      = skid_out[WIDTH-1:0];

  always_comb begin
    state_d = state_q;
    beats_d = beats_q;
    idle_d  = idle_q;
    issue   = fifo_data_valid && (state_q != IDLE) && (beats_q != '0) && (space != 2'd0);
    if (issue) beats_d = beats_q - BLEN_W'(1);
    case (state_q)
      // While a pop is still in flight the FIFO watermark/valid are one entry stale.
      IDLE: if (!pop_q && cfg_enable) begin
        if (fifo_watermark) begin
          state_d = BURST;
          beats_d = blen_eff;
        end else if (fifo_data_valid && (idle_q >= cfg_timeout)) begin
          state_d = FLUSH;
          beats_d = BLEN_W'(1);
        end
      end
      BURST:   if (issue && (beats_q == BLEN_W'(1))) state_d = IDLE;
      FLUSH:   if (issue) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if ((state_q != IDLE) || (state_d != IDLE) || !fifo_data_valid) idle_d = '0;
    else if (cfg_enable && (idle_q != '1))                          idle_d = idle_q + TMO_W'(1);
    pop_d  = issue;
    last_d = issue && (beats_q == BLEN_W'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      beats_q <= '0;
      idle_q  <= '0;
      pop_q   <= 1'b0;
      last_q  <= 1'b0;
    end else if (!sync_rst_n) begin
      state_q <= IDLE;
      beats_q <= '0;
      idle_q  <= '0;
      pop_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      beats_q <= beats_d;
      idle_q  <= idle_d;
      pop_q   <= pop_d;
      last_q  <= last_d;
    end
  end

  axis_skid_buf #(.W(WIDTH + 1)) u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .sync_rst_n (sync_rst_n),
    .in_valid   (pop_q),
    .in_data    ({last_q, fifo_pop_data}),
    .in_space   (space),
    .out_valid  (m_tvalid),
    .out_data   (skid_out),
    .out_ready  (m_tready)
  );
endmodule

// File: tb/tb_fifo_axis_egress.sv
// Directed bench: a queue stands in for the FIFO; received beats are checked against
// the loaded data order and the expected tlast pattern per scenario.
module tb_fifo_axis_egress;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0, sync_rst_n = 1'b1, cfg_enable = 1'b0;
  logic [7:0]  cfg_burst_len = 8'd4;
  logic [15:0] cfg_timeout = 16'd1000;
  logic        fifo_data_valid = 1'b0, fifo_watermark = 1'b0, m_tready = 1'b1;
  logic [7:0]  fifo_pop_data = 8'd0;
  logic        fifo_pop, m_tvalid, m_tlast, burst_active;
  logic [7:0]  m_tdata;

  fifo_axis_egress #(.WIDTH(8), .BLEN_W(8), .TMO_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .sync_rst_n(sync_rst_n), .cfg_enable(cfg_enable),
    .cfg_burst_len(cfg_burst_len), .cfg_timeout(cfg_timeout),
    .fifo_data_valid(fifo_data_valid), .fifo_pop_data(fifo_pop_data),
    .fifo_watermark(fifo_watermark), .fifo_pop(fifo_pop), .m_tvalid(m_tvalid),
    .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tready(m_tready), .burst_active(burst_active)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0, cyc = 0;
  int popped = 0, accepted = 0;
  logic [7:0] fq[$];
  logic [8:0] rx[$];
  int rx_cyc[$], pop_cyc[$];
  logic mon_p, mon_a;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic upd();
    fifo_data_valid = (fq.size() != 0);
    fifo_pop_data   = (fq.size() != 0) ? fq[0] : 8'd0;
    fifo_watermark  = (fq.size() >= ((cfg_burst_len == 8'd0) ? 1 : int'(cfg_burst_len)));
  endtask

  // Edge monitor plus the FIFO model's pop (applied just after the edge).
  always @(posedge clk) begin
    mon_p = fifo_pop;
    mon_a = m_tvalid & m_tready;
    cyc++;
    if (mon_p) begin
      chk("pop_with_valid", {31'd0, fifo_data_valid}, 32'd1);
      popped++;
      pop_cyc.push_back(cyc);
    end
    if (mon_a) begin
      rx.push_back({m_tlast, m_tdata});
      rx_cyc.push_back(cyc);
      accepted++;
    end
    if (mon_p || mon_a) chk("outstanding_le2", {31'd0, (popped - accepted) <= 2}, 32'd1);
    #1;
    if (mon_p && fq.size() != 0) void'(fq.pop_front());
    upd();
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clear();
    rx.delete(); rx_cyc.delete(); pop_cyc.delete();
    popped = 0; accepted = 0;
  endtask

  task automatic do_reset();
    cfg_enable = 1'b0;
    m_tready = 1'b1;
    rst_n = 1'b0;
    fq.delete();
    upd();
    tick(2);
    rst_n = 1'b1;
    tick(1);
    clear();
  endtask

  task automatic load(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) fq.push_back(base + 8'(i));
    upd();
  endtask

  task automatic wait_done(input int budget, input int st_at, input int st_len, input string nm);
    int k;
    k = 0;
    while (!(fq.size() == 0 && !burst_active && !m_tvalid && !fifo_pop) && k < budget) begin
      m_tready = !(k >= st_at && k < st_at + st_len);
      tick(1);
      k++;
    end
    m_tready = 1'b1;
    chk({nm, "_drained_in_budget"}, {31'd0, k < budget}, 32'd1);
  endtask

  typedef struct {
    int len; int n; int tmo; int st_at; int st_len; int exp_beats; logic [15:0] exp_last;
  } vec_t;
  vec_t tbl[9];

  initial begin
    logic [7:0] base, head;
    int k, idle;
    tbl[0] = '{len:4, n:4, tmo:1000, st_at:0,  st_len:0, exp_beats:4, exp_last:16'h0008};
    tbl[1] = '{len:4, n:4, tmo:1000, st_at:2,  st_len:4, exp_beats:4, exp_last:16'h0008};
    tbl[2] = '{len:0, n:1, tmo:1000, st_at:0,  st_len:0, exp_beats:1, exp_last:16'h0001};
    tbl[3] = '{len:3, n:6, tmo:1000, st_at:0,  st_len:0, exp_beats:6, exp_last:16'h0024};
    tbl[4] = '{len:4, n:2, tmo:0,    st_at:0,  st_len:0, exp_beats:2, exp_last:16'h0003};
    tbl[5] = '{len:2, n:2, tmo:0,    st_at:0,  st_len:0, exp_beats:2, exp_last:16'h0002};
    tbl[6] = '{len:2, n:5, tmo:0,    st_at:0,  st_len:0, exp_beats:5, exp_last:16'h001A};
    tbl[7] = '{len:1, n:3, tmo:1000, st_at:0,  st_len:0, exp_beats:3, exp_last:16'h0007};
    tbl[8] = '{len:8, n:8, tmo:1000, st_at:3,  st_len:6, exp_beats:8, exp_last:16'h0080};

    // Reset state
    tick(2);
    chk("rst_fifo_pop", {31'd0, fifo_pop}, 32'd0);
    chk("rst_tvalid", {31'd0, m_tvalid}, 32'd0);
    chk("rst_tlast", {31'd0, m_tlast}, 32'd0);
    chk("rst_active", {31'd0, burst_active}, 32'd0);
    chk("rst_tdata", {24'd0, m_tdata}, 32'd0);
    rst_n = 1'b1;
    tick(1);

    // Table-driven scenarios
    for (int v = 0; v < 9; v++) begin
      do_reset();
      cfg_burst_len = 8'(tbl[v].len);
      cfg_timeout   = 16'(tbl[v].tmo);
      base = 8'(16 * v + 1);
      load(tbl[v].n, base);
      cfg_enable = 1'b1;
      wait_done(300, tbl[v].st_at, tbl[v].st_len, $sformatf("vec%0d", v));
      chk($sformatf("vec%0d_beats", v), rx.size(), tbl[v].exp_beats);
      for (int i = 0; i < tbl[v].exp_beats && i < rx.size(); i++) begin
        chk($sformatf("vec%0d_data%0d", v, i), {23'd0, rx[i]} & 32'hFF, {24'd0, base + 8'(i)});
        chk($sformatf("vec%0d_last%0d", v, i), {31'd0, rx[i][8]}, {31'd0, tbl[v].exp_last[i]});
      end
    end

    // Back-to-back timing: 4 consecutive pops, beats one cycle behind
    do_reset();
    cfg_burst_len = 8'd4; cfg_timeout = 16'd1000;
    load(4, 8'hA0);
    cfg_enable = 1'b1;
    wait_done(100, 0, 0, "timing");
    chk("timing_pops", pop_cyc.size(), 4);
    for (int i = 0; i < 4 && i < pop_cyc.size() && i < rx_cyc.size(); i++) begin
      chk($sformatf("timing_pop%0d", i), pop_cyc[i] - pop_cyc[0], i);
      chk($sformatf("timing_beat%0d", i), rx_cyc[i] - pop_cyc[0], i + 1);
    end

    // Idle timeout: 11 idle cycles, then a flush; counter restarts for the next entry
    do_reset();
    cfg_burst_len = 8'd4; cfg_timeout = 16'd10;
    for (int r = 0; r < 2; r++) begin
      load(1, 8'hC0 + 8'(r));
      if (r == 0) cfg_enable = 1'b1;
      idle = 0; k = 0;
      while (!burst_active && k < 50) begin idle++; tick(1); k++; end
      chk($sformatf("tmo%0d_idle_cycles", r), idle, 11);
      wait_done(50, 0, 0, $sformatf("tmo%0d", r));
      chk($sformatf("tmo%0d_beats", r), rx.size(), r + 1);
      if (rx.size() == r + 1) chk($sformatf("tmo%0d_beat", r), {23'd0, rx[r]}, {23'd0, 1'b1, 8'hC0 + 8'(r)});
      tick(3);
    end

    // cfg_enable drop mid-burst plus mid-burst length change
    do_reset();
    cfg_burst_len = 8'd8; cfg_timeout = 16'd1000;
    load(16, 8'h40);
    cfg_enable = 1'b1;
    k = 0;
    while (accepted < 2 && k < 50) begin tick(1); k++; end
    chk("endrop_reach2", {31'd0, k < 50}, 32'd1);
    cfg_enable = 1'b0;
    cfg_burst_len = 8'd2;
    upd();
    tick(40);
    chk("endrop_beats", rx.size(), 8);
    chk("endrop_active", {31'd0, burst_active}, 32'd0);
    chk("endrop_left", fq.size(), 8);
    if (rx.size() == 8) begin
      chk("endrop_last7", {23'd0, rx[7]}, {23'd0, 1'b1, 8'h47});
      chk("endrop_last6", {31'd0, rx[6][8]}, 32'd0);
    end

    // Asynchronous reset mid-burst, then a clean full-length burst
    do_reset();
    cfg_burst_len = 8'd4; cfg_timeout = 16'd1000;
    load(8, 8'h80);
    cfg_enable = 1'b1;
    k = 0;
    while (popped < 2 && k < 50) begin tick(1); k++; end
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_tvalid", {31'd0, m_tvalid}, 32'd0);
    chk("arst_pop", {31'd0, fifo_pop}, 32'd0);
    chk("arst_active", {31'd0, burst_active}, 32'd0);
    cfg_enable = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    clear();
    head = fq[0];
    cfg_enable = 1'b1;
    k = 0;
    while (accepted < 1 && k < 50) begin tick(1); k++; end
    cfg_enable = 1'b0;
    tick(20);
    chk("arst_beats", rx.size(), 4);
    for (int i = 0; i < 4 && i < rx.size(); i++)
      chk($sformatf("arst_beat%0d", i), {23'd0, rx[i]}, {23'd0, (i == 3), head + 8'(i)});

    // Synchronous clear mid-burst
    do_reset();
    cfg_burst_len = 8'd8;
    load(8, 8'h20);
    cfg_enable = 1'b1;
    k = 0;
    while (accepted < 1 && k < 50) begin tick(1); k++; end
    cfg_enable = 1'b0;
    sync_rst_n = 1'b0;
    tick(1);
    sync_rst_n = 1'b1;
    chk("srst_tvalid", {31'd0, m_tvalid}, 32'd0);
    chk("srst_pop", {31'd0, fifo_pop}, 32'd0);
    chk("srst_active", {31'd0, burst_active}, 32'd0);
    chk("srst_tdata", {24'd0, m_tdata}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1);
  end
endmodule
